// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency imem request/ack
// port and presents {PC+4, instruction, valid} to the IF/ID register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | request to pc outstanding; ack data bypassed straight to IF/ID
// HOLD    | instruction buffered while IF/ID is frozen; no request issued
// DISCARD | stale request (pre-branch) still in flight; its data is dropped
module if_fetch_stage #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WORD_WIDTH-1:0] PC_STEP    = WORD_WIDTH'(4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ack,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic                  fetch_valid
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   pc_q, pc_d;
  logic [WORD_WIDTH-1:0]   buf_q, buf_d;
  logic [WORD_WIDTH-1:0]   disc_addr_q, disc_addr_d;
  logic [WORD_WIDTH-1:0]   pc_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      buf_q       <= '0;
      disc_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      disc_addr_q <= disc_addr_d;
    end
  end

  // Request side depends on registered state only, so ack never loops back to req.
  always_comb begin
    pc_inc          = pc_q + PC_STEP;
    imem_req        = (state_q != S_HOLD);
    imem_addr       = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
    fetch_valid     = ~branch_taken &
                      ((state_q == S_HOLD) | ((state_q == S_FETCH) & imem_ack));
    instruction_out = '0;
    if (state_q == S_HOLD) begin
      instruction_out = buf_q;
    end else if ((state_q == S_FETCH) && imem_ack) begin
      instruction_out = imem_rdata;
    end
    pc_out = fetch_valid ? pc_inc : '0;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    disc_addr_d = disc_addr_q;
    if (branch_taken) begin
      pc_d = branch_addr;
      case (state_q)
        S_FETCH: begin
          // Remember the abandoned address so imem_addr stays stable until its ack.
          if (!imem_ack) begin
            state_d     = S_DISCARD;
            disc_addr_d = pc_q;
          end
        end
        S_HOLD:    state_d = S_FETCH;
        S_DISCARD: if (imem_ack) state_d = S_FETCH;
        default:   state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            if (freeze) begin
              buf_d   = imem_rdata;
              state_d = S_HOLD;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
        S_DISCARD: if (imem_ack) state_d = S_FETCH;
        default:   state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed test-plan sequences followed by random traffic,
// checked against a transaction-level model of the delivered instruction stream.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc_out, instruction_out;
  logic        fetch_valid;

  int checks   = 0;
  int failures = 0;
  int consumes = 0;

  // memory model
  int lat_mode   = 0;   // <0: random 0..3 wait cycles
  bit mem_active = 0;
  int mem_wait   = 0;

  // reference model of the instruction stream
  logic [31:0] exp_pc;
  bit          holding, stale, busy;
  logic [31:0] busy_addr;

  if_fetch_stage #(.WORD_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc_out(pc_out),
    .instruction_out(instruction_out), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc     = 32'h0;
    holding    = 0;
    stale      = 0;
    busy       = 0;
    mem_active = 0;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    logic        ack_v;
    logic [31:0] rdata_v;
    logic        exp_valid;
    rst          = r;
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    ack_v        = 1'b0;
    rdata_v      = $urandom;
    if (!r && imem_req) begin
      if (!mem_active) begin
        mem_active = 1;
        mem_wait   = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      if (mem_wait == 0) begin
        ack_v   = 1'b1;
        rdata_v = imem_addr ^ 32'hE000_0000;
      end
    end
    imem_ack   = ack_v;
    imem_rdata = rdata_v;
    #1;
    if (!r) begin
      exp_valid = !b && (holding || (ack_v && !stale));
      chk("imem_req", {31'b0, imem_req}, {31'b0, !holding});
      if (imem_req) begin
        if (busy)        chk("addr_stable", imem_addr, busy_addr);
        else if (!stale) chk("imem_addr", imem_addr, exp_pc);
      end
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("pc_out", pc_out, exp_pc + 32'd4);
        chk("instruction_out", instruction_out, exp_pc ^ 32'hE000_0000);
      end else begin
        chk("pc_out_idle", pc_out, 32'h0);
        if (!holding && !ack_v) chk("instr_idle", instruction_out, 32'h0);
      end
      // memory bookkeeping
      if (ack_v) begin
        busy = 0; stale = 0; mem_active = 0;
      end else if (imem_req) begin
        busy = 1; busy_addr = imem_addr;
        if (mem_active) mem_wait--;
      end
      // stream bookkeeping
      if (b) begin
        exp_pc  = ba;
        holding = 0;
        if (imem_req && !ack_v) stale = 1;
      end else if (exp_valid) begin
        if (f) holding = 1;
        else begin
          exp_pc  = exp_pc + 32'd4;
          holding = 0;
          consumes++;
        end
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0;
    imem_ack = 0; imem_rdata = 0;
    model_reset();
    @(posedge clk); #1;
    step(1, 0, 0, 0);

    // zero-wait streaming
    lat_mode = 0;
    repeat (6) step(0, 0, 0, 0);

    // 3-cycle latency
    lat_mode = 2;
    repeat (9) step(0, 0, 0, 0);

    // freeze over ack at pc=8
    step(1, 0, 0, 0);
    lat_mode = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // branch while request to 0x10 outstanding
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    lat_mode = 2;
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    repeat (4) step(0, 0, 0, 0);

    // second branch during DISCARD, then branch+freeze in HOLD
    step(0, 0, 1, 32'h180);
    step(0, 0, 1, 32'h200);
    repeat (4) step(0, 0, 0, 0);
    lat_mode = 0;
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h300);
    repeat (3) step(0, 0, 0, 0);

    // reset mid-request and in HOLD
    lat_mode = 3;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    lat_mode = 0;
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);

    // pc wrap
    step(0, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 0, 0);

    // random traffic
    lat_mode = -1;
    for (int i = 0; i < 600; i++) begin
      logic        r_v, f_v, b_v;
      logic [31:0] a_v;
      r_v = ($urandom_range(0, 99) == 0);
      f_v = ($urandom_range(0, 2) == 0);
      b_v = ($urandom_range(0, 7) == 0);
      a_v = $urandom & 32'hFFFF_FFFC;
      step(r_v, f_v, b_v, a_v);
    end

    chk("liveness", {31'b0, (consumes >= 100)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives a variable-latency instruction-memory request/ack interface.
- Presents {PC+4, instruction, valid} to the IF/ID register, honours the hazard-unit freeze, and redirects on taken branches from EX.
- An in-flight memory response that a branch makes stale is discarded, never forwarded.

Parameters:
- WORD_WIDTH, 32: width of PC, addresses and instructions.
- RESET_PC, 0: PC value loaded on reset.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  IF/ID register is holding this cycle; the current instruction is not consumed.
- branch_taken  in  1  redirect fetch to branch_addr; wins over freeze.
- branch_addr  in  WORD_WIDTH  branch target byte address.
- imem_req  out  1  memory request; held high until imem_ack.
- imem_addr  out  WORD_WIDTH  request address; stable while imem_req is high.
- imem_rdata  in  WORD_WIDTH  instruction word; valid only in the imem_ack cycle.
- imem_ack  in  1  single-cycle completion pulse; may arrive in the same cycle as imem_req (zero wait).
- pc_out  out  WORD_WIDTH  fetched PC + PC_STEP, modulo 2^WORD_WIDTH.
- instruction_out  out  WORD_WIDTH  fetched instruction word.
- fetch_valid  out  1  pc_out and instruction_out are meaningful this cycle.

Behaviour:
- State: pc register (address currently being fetched), instruction buffer, FSM with states FETCH, HOLD, DISCARD.
- Reset, synchronous and highest priority:
  - pc <= RESET_PC, state <= FETCH, buffer <= 0.
  - The in-flight memory transaction is abandoned; imem shares rst.
  - In the first cycle after reset: imem_req = 1, imem_addr = RESET_PC.
- imem_req = 1 in FETCH and DISCARD, 0 in HOLD.
- imem_addr = pc in FETCH. In DISCARD it is the address of the abandoned request, held in a separate register.
- fetch_valid = ~branch_taken & ((state == HOLD) | (state == FETCH & imem_ack)).
- instruction_out:
  - HOLD: buffer.
  - FETCH with ack: imem_rdata (combinational bypass, zero added latency).
  - Otherwise: 0.
- pc_out = pc + PC_STEP when fetch_valid = 1, else 0.
- consume = fetch_valid & ~freeze. On consume: pc <= pc + PC_STEP, state <= FETCH.
- Sustained throughput with a zero-wait memory and no freeze is 1 instruction per cycle.
- FETCH transitions:
  - ack with freeze: buffer <= imem_rdata, state <= HOLD.
  - no ack: stay in FETCH, request held.
- HOLD transitions:
  - freeze: stay; outputs stable.
  - ~freeze: consume, state <= FETCH.
- Branch (any state, rst low): pc <= branch_addr. Next state:
  - FETCH without ack: DISCARD.
  - FETCH with ack: FETCH (data dropped).
  - HOLD: FETCH (buffer dropped).
  - DISCARD without ack: DISCARD (latest branch_addr wins).
  - DISCARD with ack: FETCH.
- DISCARD without branch: wait for imem_ack, drop imem_rdata, state <= FETCH. fetch_valid = 0 throughout.
- Simultaneous branch_taken and freeze: branch wins and no instruction is consumed.
- PC wrap: pc + PC_STEP wraps modulo 2^WORD_WIDTH with no flag.
- No combinational path from imem_ack to imem_req.

Test Plan:
- Reset, zero-wait memory (ack same cycle as req, rdata = addr ^ 32'hE000_0000), no freeze -> imem_addr 0,4,8,12 on consecutive cycles; pc_out 4,8,12,16; fetch_valid = 1 every cycle.
- 3-cycle memory latency -> imem_req high for 3 cycles with addr stable; fetch_valid = 1 only in ack cycles; pc advances by 4 per ack.
- freeze high for 4 cycles over an ack at pc = 8 -> HOLD; instruction_out and pc_out = 12 held stable; imem_req = 0; after release exactly one consume, then request at addr 12.
- branch_taken with branch_addr = 0x100 while a request to 0x10 is outstanding (ack 2 cycles later) -> fetch_valid = 0, 0x10 data never output; next request at 0x100.
- Second branch to 0x200 during DISCARD, then ack -> next imem_addr = 0x200; branch and freeze in the same cycle in HOLD -> buffer dropped, fetch from branch_addr.
- rst asserted mid-request and in HOLD -> next cycle: state FETCH, imem_addr = RESET_PC, fetch_valid = 0 until the next ack; pc = 0xFFFF_FFFC consumed -> pc_out = 0, pc wraps to 0.
